// File: rtl/fetch_align_pkg.sv
// rtl/fetch_align_pkg.sv - shared constants and types for the fetch/align stage
// Contents: reset PC, decoder step encodings, halfword/word types, step decode helper.
package fetch_align_pkg;

    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

    localparam logic [1:0] STEP_16 = 2'h1;
    localparam logic [1:0] STEP_32 = 2'h2;

    typedef logic [15:0] halfword_t;
    typedef logic [31:0] word_t;

    // Encodings 0 and 3 alias to the nearest legal step (1 and 2 halfwords).
    function automatic logic [1:0] step_halfwords(input logic [1:0] step);
        return (step == 2'd2 || step == 2'd3) ? STEP_32 : STEP_16;
    endfunction

endpackage

// File: rtl/hw_queue.sv
// rtl/hw_queue.sv - QDEPTH x 16 circular halfword queue with dual push/pop
// Ports: clk, resetN (async active-low), flush, push_n/push_lo/push_hi (0..2 writes),
//        pop_n (0..2 reads), count_next (post-update occupancy), two_valid (registered
//        count >= 2), head/head1 (slots at read pointer and read pointer + 1).
module hw_queue
    import fetch_align_pkg::*;
#(
    parameter int QDEPTH = 8
) (
    input  logic                      clk,
    input  logic                      resetN,
    input  logic                      flush,
    input  logic [1:0]                push_n,
    input  halfword_t                 push_lo,
    input  halfword_t                 push_hi,
    input  logic [1:0]                pop_n,
    output logic [$clog2(QDEPTH):0]   count_next,
    output logic                      two_valid,
    output halfword_t                 head,
    output halfword_t                 head1
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    halfword_t       mem [QDEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr1;
    logic [PW-1:0]   wr_ptr1;
    logic [CW-1:0]   count;

    // Pointers are exactly log2(QDEPTH) wide, so +1 wraps naturally.
    assign rd_ptr1 = rd_ptr + PW'(1);
    assign wr_ptr1 = wr_ptr + PW'(1);

    assign head  = mem[rd_ptr];
    assign head1 = mem[rd_ptr1];

    assign count_next = flush ? '0 : (count + CW'(push_n) - CW'(pop_n));

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            two_valid <= 1'b0;
            for (int i = 0; i < QDEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            count     <= count_next;
            two_valid <= (count_next >= CW'(2));
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push_n != 2'd0) begin
                    mem[wr_ptr] <= push_lo;
                end
                if (push_n == 2'd2) begin
                    mem[wr_ptr1] <= push_hi;
                end
                wr_ptr <= wr_ptr + PW'(push_n);
                rd_ptr <= rd_ptr + PW'(pop_n);
            end
        end
    end

endmodule

// File: rtl/fetch_align.sv
// rtl/fetch_align.sv - instruction fetch and halfword alignment ahead of the decoder
// Ports: clk, resetN (async active-low); memReq/memAddr/memAck/memData fetch port;
//        istrWord/istrPc/istrValid decode window; idAdvance/idStepPc decoder consume;
//        brRedirect/brTarget branch redirect.
module fetch_align
    import fetch_align_pkg::*;
#(
    parameter int          QDEPTH   = 8,
    parameter logic [31:0] RESET_PC = FETCH_RESET_PC
) (
    input  logic        clk,
    input  logic        resetN,
    output logic        memReq,
    output logic [31:0] memAddr,
    input  logic        memAck,
    input  logic [31:0] memData,
    output logic [31:0] istrWord,
    output logic [31:0] istrPc,
    output logic        istrValid,
    input  logic        idAdvance,
    input  logic [1:0]  idStepPc,
    input  logic        brRedirect,
    input  logic [31:0] brTarget
);

    localparam int CW = $clog2(QDEPTH) + 1;

    word_t           fetch_pc;
    word_t           fetch_pc_next;
    logic            pending;
    logic            kill;
    logic            skip_hi;
    logic            ack_acc;
    logic            ack_use;
    logic            pop_en;
    logic            issue;
    logic [1:0]      step;
    logic [1:0]      push_n;
    logic [1:0]      pop_n;
    logic [CW-1:0]   count_next;
    halfword_t       head;
    halfword_t       head1;

    assign step = step_halfwords(idStepPc);

    // A stray ack with nothing outstanding is ignored.
    assign ack_acc = memAck & pending;
    assign ack_use = ack_acc & ~kill & ~brRedirect;
    assign pop_en  = idAdvance & istrValid & ~brRedirect;
    assign pop_n   = pop_en ? step : 2'd0;
    assign push_n  = ack_use ? (skip_hi ? 2'd1 : 2'd2) : 2'd0;

    assign fetch_pc_next = brRedirect ? (brTarget & ~32'd3)
                         : ack_use    ? (fetch_pc + 32'd4)
                         :              fetch_pc;

    // Issue decision uses the post-update occupancy, which reserves room for
    // the whole response and lets a new request follow an ack back to back.
    assign issue = (~pending | ack_acc) & (count_next <= CW'(QDEPTH - 2));

    assign memReq   = pending;
    assign istrWord = {head1, head};

    hw_queue #(
        .QDEPTH (QDEPTH)
    ) u_queue (
        .clk        (clk),
        .resetN     (resetN),
        .flush      (brRedirect),
        .push_n     (push_n),
        .push_lo    (skip_hi ? memData[31:16] : memData[15:0]),
        .push_hi    (memData[31:16]),
        .pop_n      (pop_n),
        .count_next (count_next),
        .two_valid  (istrValid),
        .head       (head),
        .head1      (head1)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            fetch_pc <= RESET_PC;
            memAddr  <= RESET_PC;
            istrPc   <= RESET_PC;
            pending  <= 1'b0;
            kill     <= 1'b0;
            skip_hi  <= 1'b0;
        end else begin
            fetch_pc <= fetch_pc_next;

            // memAddr only moves when a new request is issued, so a killed
            // request keeps its address on the bus until acked.
            if (issue) begin
                memAddr <= fetch_pc_next;
                pending <= 1'b1;
            end else if (ack_acc) begin
                pending <= 1'b0;
            end

            if (brRedirect) begin
                kill    <= pending & ~ack_acc;
                skip_hi <= brTarget[1];
                istrPc  <= brTarget & ~32'd1;
            end else begin
                if (ack_acc) begin
                    kill <= 1'b0;
                end
                if (ack_use) begin
                    skip_hi <= 1'b0;
                end
                if (pop_en) begin
                    istrPc <= istrPc + {29'd0, step, 1'b0};
                end
            end
        end
    end

endmodule

// File: doc/fetch_align.md
# fetch_align

Instruction fetch/alignment stage directly upstream of the instruction decoder. Issues 32-bit aligned fetches to the instruction memory port and buffers returned halfwords in a small circular queue. Presents the decoder with a 32-bit window (`istrWord`: first word in [15:0], second in [31:16]) and the PC of the first word. Consumes 1 or 2 halfwords per decoder advance according to the decoder's `idStepPc`, and flushes and refetches on branch redirect.

## Interface
- `QDEPTH`, 8: queue depth in halfwords; power of two, >= 4.
- `RESET_PC`, 32'h0000_0000: fetch/decode PC after reset.

- `clk`  in  1  clock, rising edge.
- `resetN`  in  1  asynchronous, active-low reset.
- `memReq`  out  1  fetch request; held until `memAck`.
- `memAddr`  out  32  fetch address, bits [1:0] always 0; stable while `memReq`.
- `memAck`  in  1  `memData` valid this cycle; completes the request.
- `memData`  in  32  [15:0] = halfword at `memAddr`, [31:16] = halfword at `memAddr`+2.
- `istrWord`  out  32  decode window; [15:0] = queue head, [31:16] = head+1.
- `istrPc`  out  32  address of `istrWord[15:0]`; bit 0 always 0.
- `istrValid`  out  1  queue holds >= 2 halfwords.
- `idAdvance`  in  1  decoder consumes the current window this cycle.
- `idStepPc`  in  2  halfwords consumed: 1 -> 1, 2 -> 2, 0 treated as 1, 3 treated as 2.
- `brRedirect`  in  1  redirect fetch/decode to `brTarget`.
- `brTarget`  in  32  redirect target; bit 0 ignored.

## Operation
- State: `fetchPc` (next fetch address), `decPc` (`istrPc`), queue `count` (0..QDEPTH), `pending` (one request outstanding), `kill` (outstanding response to discard), `skipHi` (drop the low halfword of the next accepted response).
- At most one outstanding request.
- A new request is raised only when `pending`=0 and `count` <= QDEPTH-2. Space is reserved at issue, so an ack always fits.
- On ack with `kill`=0:
  - push both halfwords, or only [31:16] if `skipHi`=1;
  - `fetchPc` += 4;
  - clear `skipHi`.
- On ack with `kill`=1: discard data, clear `kill` and `pending`; `fetchPc` unchanged (already retargeted).
- `idAdvance` with `istrValid`=1: pop `step` halfwords; `decPc` += 2*`step`. Ignored when `istrValid`=0.
- Same-cycle ack and advance: `count` <= `count` + pushed − popped.
- `brRedirect` has priority over ack data and advance:
  - `count` <= 0;
  - `decPc` <= `brTarget` & ~1;
  - `fetchPc` <= `brTarget` & ~3;
  - `skipHi` <= `brTarget[1]`.
  - If a request is outstanding and not acked this cycle: `kill` <= 1.
  - If acked this same cycle: data dropped, `pending` cleared, no kill.
- Queue pointers wrap modulo QDEPTH. Both push slots and both pop slots may cross the wrap boundary.
- `istrWord[31:16]` reads the head+1 slot regardless of `count`. Its content is unspecified when `istrValid`=0.

## Timing
- Reset values (async, immediate):
  - `memReq`=0, `memAddr`=RESET_PC, `istrValid`=0, `istrWord`=0, `istrPc`=RESET_PC;
  - `count`=0, `pending`=0, `kill`=0, `skipHi`=0.
- First `memReq` is in the first rising edge's cycle after `resetN` deasserts.
- Ack in cycle N -> `istrValid`/`istrWord` reflect pushed data in cycle N+1. Next request may assert in N+1.
- `idAdvance` in cycle N -> new window and `istrPc` in N+1. `istrValid` drops in N+1 if fewer than 2 halfwords remain.
- `brRedirect` in cycle N -> `istrValid`=0 in N+1. New-target `memReq` in N+1 if nothing is pending, else in the cycle after the killed ack.
- `resetN` asserted mid-request: request abandoned. A later stray `memAck` while `pending`=0 is ignored.
- Outputs `istrWord`, `istrValid`, `istrPc`, `memReq`, `memAddr` come straight from registers or queue storage. There is no combinational path from `idAdvance`/`brRedirect` to outputs.

## Structure
- Shared package: `FETCH_RESET_PC`, step encodings (`STEP_16`=2'h1, `STEP_32`=2'h2), halfword/word typedefs.
- Sub-module `hw_queue`: QDEPTH×16 circular buffer with 0/1/2-entry push, 0/1/2-entry pop, flush, and `count`/head/head+1 read ports.
- `fetch_align` holds the PC registers, request/kill control, and the redirect logic.

## Test plan
- Reset, memory acks every request one cycle late with incrementing data -> `memAddr` 0,4,8…; `istrValid` in cycle 2 after first ack latency; `istrWord`=32'h0001_0000 at `istrPc`=0.
- Hold `idAdvance`=0 -> requests stop when `count`=QDEPTH-1 or QDEPTH; `memReq` never asserts with `count`>QDEPTH-2; no data lost.
- Alternating `idStepPc`=1,2 with continuous advance -> `istrPc` sequence 0,2,6,8,12; `istrWord` matches memory image across queue wrap.
- `brRedirect` to 32'h0000_0102 while a request to 0x20 is pending, ack 3 cycles later -> 0x20 data discarded; next `memAddr`=0x100; first window `istrWord[15:0]` = halfword at 0x102; `istrPc`=0x102.
- `brRedirect` coinciding with `memAck` and `idAdvance` -> ack data dropped, no kill; `count`=0 next cycle; next request is to the target.
- Assert `resetN`=0 mid-pending, then a stray `memAck` after release -> outputs at reset values immediately; stray ack ignored; fetch restarts at RESET_PC.
